ifu_fetch: RTL

- Receiving end of the branch-redirect interface: owns the architectural fetch PC and accepts `i_redirect` / `i_redirect_pc` from the branch unit in IDU.
- Issues single-outstanding instruction-memory requests with a valid/ready handshake.
- Holds each returned instruction in a skid register and presents it to IDU with its PC.
- Squashes stale in-flight or held instructions whenever a redirect arrives.

---
 rtl/ifu_fetch_pkg.sv | 21 ++
 rtl/stl_reg.sv | 30 +++
 rtl/ifu_fetch.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared definitions for the instruction fetch unit.
//   CPU_WIDTH     - PC / fetch address width
//   INST_WIDTH    - instruction width
//   RESET_PC      - first fetch address after reset
//   fetch_state_t - fetch FSM states:
//                     REQ  : request is being offered to instruction memory
//                     WAIT : one request outstanding, waiting for its response
//                     HOLD : instruction held in the skid register for IDU
package ifu_fetch_pkg;

  localparam int          CPU_WIDTH  = 64;
  localparam int          INST_WIDTH = 32;
  localparam logic [63:0] RESET_PC   = 64'h8000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/stl_reg.sv
// stl_reg: generic enable-loaded register with asynchronous active-low reset.
//   i_clk   - clock
//   i_rst_n - asynchronous active-low reset, loads RESET_VAL
//   i_wen   - load enable
//   i_din   - data to load when i_wen=1
//   o_dout  - registered value
module stl_reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wen,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dout_q <= RESET_VAL;
    end else if (i_wen) begin
      dout_q <= i_din;
    end
  end

  assign o_dout = dout_q;

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit. Owns the architectural fetch PC, issues
// single-outstanding instruction-memory requests, holds each returned
// instruction in a skid register for IDU and squashes stale fetches when the
// branch unit redirects.
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are 1. Once raised, o_imem_req_valid stays up until accepted (its
// address may change if a redirect arrives meanwhile); o_idu_valid stays up
// with stable o_idu_inst / o_idu_pc until accepted or flushed by i_redirect.
// The response channel has no ready: i_imem_resp_valid is a one-cycle pulse.
//
// Ports:
//   i_clk, i_rst_n          - clock, asynchronous active-low reset
//   i_redirect              - jump/flush strobe from the branch unit
//   i_redirect_pc           - redirect target (low two bits ignored)
//   o_imem_req_valid        - fetch request valid
//   i_imem_req_ready        - memory accepts the request
//   o_imem_req_addr         - fetch address
//   i_imem_resp_valid       - response valid (never backpressured)
//   i_imem_resp_data        - returned instruction
//   o_idu_valid             - instruction valid to IDU
//   i_idu_ready             - IDU accepts
//   o_idu_inst, o_idu_pc    - instruction and its PC
//   o_dbg_state             - current fetch_state_t encoding, for observation
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int                   CPU_WIDTH  = ifu_fetch_pkg::CPU_WIDTH,
  parameter int                   INST_WIDTH = ifu_fetch_pkg::INST_WIDTH,
  parameter logic [CPU_WIDTH-1:0] RESET_PC   = CPU_WIDTH'(ifu_fetch_pkg::RESET_PC)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_redirect,
  input  logic [CPU_WIDTH-1:0]  i_redirect_pc,
  output logic                  o_imem_req_valid,
  input  logic                  i_imem_req_ready,
  output logic [CPU_WIDTH-1:0]  o_imem_req_addr,
  input  logic                  i_imem_resp_valid,
  input  logic [INST_WIDTH-1:0] i_imem_resp_data,
  output logic                  o_idu_valid,
  input  logic                  i_idu_ready,
  output logic [INST_WIDTH-1:0] o_idu_inst,
  output logic [CPU_WIDTH-1:0]  o_idu_pc,
  output logic [1:0]            o_dbg_state
);

  fetch_state_t         state_q, state_d;
  logic                 kill_q, kill_d;
  // Set by reset, cleared by the first accepted request: a response that was
  // in flight when reset hit may still land while we sit in REQ.
  logic                 resp_exempt_q, resp_exempt_d;

  logic [CPU_WIDTH-1:0] pc_q, pc_d;
  logic                 pc_wen;
  logic [CPU_WIDTH-1:0] tag_q;
  logic                 tag_wen;
  logic                 inst_wen;
  logic [CPU_WIDTH-1:0] redirect_tgt;

  // Fetch addresses are always word aligned.
  assign redirect_tgt = i_redirect_pc & ~CPU_WIDTH'(3);

  // ---------------------------------------------------------------- datapath
  stl_reg #(.WIDTH(CPU_WIDTH), .RESET_VAL(RESET_PC)) u_pc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wen   (pc_wen),
    .i_din   (pc_d),
    .o_dout  (pc_q)
  );

  // PC tag of the outstanding / held instruction, captured at request accept.
  stl_reg #(.WIDTH(CPU_WIDTH), .RESET_VAL('0)) u_tag (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wen   (tag_wen),
    .i_din   (pc_q),
    .o_dout  (tag_q)
  );

  stl_reg #(.WIDTH(INST_WIDTH), .RESET_VAL('0)) u_inst (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wen   (inst_wen),
    .i_din   (i_imem_resp_data),
    .o_dout  (o_idu_inst)
  );

  // ------------------------------------------------------------- FSM state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= REQ;
      kill_q        <= 1'b0;
      resp_exempt_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      kill_q        <= kill_d;
      resp_exempt_q <= resp_exempt_d;
    end
  end

  // ------------------------------------------------------ FSM next state
  always_comb begin
    state_d       = state_q;
    kill_d        = kill_q;
    resp_exempt_d = resp_exempt_q;
    pc_wen        = 1'b0;
    pc_d          = redirect_tgt;
    tag_wen       = 1'b0;
    inst_wen      = 1'b0;

    unique case (state_q)
      REQ: begin
        // Request is accepted even when a redirect arrives the same cycle;
        // the fetch is then stale and its response must be dropped.
        if (i_imem_req_ready) begin
          state_d       = WAIT;
          tag_wen       = 1'b1;
          kill_d        = i_redirect;
          resp_exempt_d = 1'b0;
        end
        pc_wen = i_redirect;
      end

      WAIT: begin
        if (i_imem_resp_valid) begin
          kill_d = 1'b0;
          if (kill_q || i_redirect) begin
            state_d = REQ;
          end else begin
            state_d  = HOLD;
            inst_wen = 1'b1;
          end
        end else if (i_redirect) begin
          kill_d = 1'b1;
        end
        pc_wen = i_redirect;
      end

      HOLD: begin
        // A redirect wins over a same-cycle IDU handshake.
        if (i_redirect) begin
          state_d = REQ;
          pc_wen  = 1'b1;
        end else if (i_idu_ready) begin
          state_d = REQ;
          pc_wen  = 1'b1;
          pc_d    = pc_q + CPU_WIDTH'(4);
        end
      end

      default: begin
        state_d = REQ;
      end
    endcase
  end

  // ------------------------------------------------------------- outputs
  assign o_imem_req_valid = (state_q == REQ) && i_rst_n;
  assign o_imem_req_addr  = pc_q;
  assign o_idu_valid      = (state_q == HOLD);
  assign o_idu_pc         = tag_q;
  assign o_dbg_state      = state_q;

  // Responses only belong in WAIT; elsewhere they are ignored and indicate a
  // memory-side protocol error (except leftovers from before a reset).
  resp_only_in_wait: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
      !(i_imem_resp_valid &&
        ((state_q == HOLD) || ((state_q == REQ) && !resp_exempt_q)))
  );

endmodule
